// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential instruction-memory requests into a small
// prefetch buffer and handles redirects, including one that arrives while a request is in flight.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        flush_i,
   input  logic [31:0] target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   input  logic        ready_i
);

   localparam int               CNT_W   = $clog2(BUF_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_FULL  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_fetch_pc;
   logic [31:0]      w_fetch_pc_nxt;
   logic [31:0]      r_addr;
   logic [31:0]      w_addr_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic [CNT_W-1:0] w_wr_idx;
   logic             r_req;
   logic             w_req_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             w_push;
   logic             w_pop;
   logic [31:0]      r_buf_pc        [BUF_DEPTH];
   logic [31:0]      r_buf_instr     [BUF_DEPTH];
   logic [31:0]      w_buf_pc_nxt    [BUF_DEPTH];
   logic [31:0]      w_buf_instr_nxt [BUF_DEPTH];

   assign w_pop    = r_valid & ready_i & ~flush_i;
   assign w_push   = (r_state == ST_REQ) & imem_ack_i & ~flush_i;
   assign w_wr_idx = w_pop ? (r_count - ONE_C) : r_count;

   // Occupancy and fetch address; a flush overrides any same-cycle push or pop.
   always_comb begin
      w_count_nxt    = r_count;
      w_fetch_pc_nxt = r_fetch_pc;
      if (flush_i) begin
         w_count_nxt    = ZERO_C;
         w_fetch_pc_nxt = {target_i[31:2], 2'b00};
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + ONE_C;
            2'b01:   w_count_nxt = r_count - ONE_C;
            default: w_count_nxt = r_count;
         endcase
         w_fetch_pc_nxt = w_push ? (r_fetch_pc + 32'd4) : r_fetch_pc;
      end
   end

   // Fetch sequencing.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: w_state_nxt = start_i ? ST_REQ : ST_IDLE;
         ST_REQ: begin
            if (flush_i) begin
               w_state_nxt = imem_ack_i ? ST_REQ : ST_DRAIN;
            end else if (imem_ack_i) begin
               w_state_nxt = (w_count_nxt < DEPTH_C) ? ST_REQ : ST_FULL;
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_FULL:  w_state_nxt = (flush_i | w_pop) ? ST_REQ : ST_FULL;
         ST_DRAIN: w_state_nxt = imem_ack_i ? ST_REQ : ST_DRAIN;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // While draining, the abandoned request keeps its original address on the bus.
   always_comb begin
      w_addr_nxt  = (w_state_nxt == ST_DRAIN) ? r_addr : w_fetch_pc_nxt;
      w_req_nxt   = (w_state_nxt == ST_REQ) | (w_state_nxt == ST_DRAIN);
      w_valid_nxt = (w_count_nxt != ZERO_C);
   end

   // Shift-down buffer: entry 0 is the head, pushes land just above the survivors.
   always_comb begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
         w_buf_pc_nxt[i]    = (w_pop && (i < BUF_DEPTH - 1)) ? r_buf_pc[(i + 1) % BUF_DEPTH]
                                                             : r_buf_pc[i];
         w_buf_instr_nxt[i] = (w_pop && (i < BUF_DEPTH - 1)) ? r_buf_instr[(i + 1) % BUF_DEPTH]
                                                             : r_buf_instr[i];
         if (w_push && (w_wr_idx == CNT_W'(i))) begin
            w_buf_pc_nxt[i]    = r_fetch_pc;
            w_buf_instr_nxt[i] = imem_data_i;
         end else begin
            w_buf_pc_nxt[i]    = w_buf_pc_nxt[i];
            w_buf_instr_nxt[i] = w_buf_instr_nxt[i];
         end
      end
   end

   // Control and bus-facing registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC;
         r_addr     <= RESET_PC;
         r_count    <= ZERO_C;
         r_req      <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_addr     <= w_addr_nxt;
         r_count    <= w_count_nxt;
         r_req      <= w_req_nxt;
         r_valid    <= w_valid_nxt;
      end
   end

   // Prefetch buffer storage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_buf_pc[i]    <= 32'd0;
            r_buf_instr[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_buf_pc[i]    <= w_buf_pc_nxt[i];
            r_buf_instr[i] <= w_buf_instr_nxt[i];
         end
      end
   end

   assign imem_req_o  = r_req;
   assign imem_addr_o = r_addr;
   assign valid_o     = r_valid;
   assign pc_o        = r_buf_pc[0];
   assign instr_o     = r_buf_instr[0];

endmodule
